// File: rtl/byte_serializer_pkg.sv
// byte_serializer_pkg: shared state type and default sizing for byte_serializer
package byte_serializer_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
  localparam int SER_DATA_W = 8;
  localparam int SER_CLKS_PER_BIT = 1;
endpackage

// File: rtl/byte_serializer_pacer.sv
// byte_serializer_pacer: bit-period counter 0..CLKS_PER_BIT-1 with wrap strobe and sync clear
//   clk, rst_n (async active-low); clr: restart at 0; en: count this cycle
//   wrap: counter is on its last cycle while enabled; cnt_nxt: counter value after this edge
module byte_serializer_pacer
  import byte_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = SER_CLKS_PER_BIT,
  localparam int PW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic          wrap,
  output logic [PW-1:0] cnt_nxt
);
  logic [PW-1:0] cnt;
  assign wrap = en && cnt == PW'(CLKS_PER_BIT - 1);
  assign cnt_nxt = clr || wrap ? '0 : en ? cnt + PW'(1) : cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: valid/ready word-to-serial converter with per-bit shift_enable strobe
//   clk, rst_n (async active-low)
//   in_data/in_valid/in_ready: word handshake; serial_out: current bit (0 when idle)
//   shift_enable: last cycle of each bit period; byte_done: final bit's strobe; busy: frame in progress
//   BYTE_SERIALIZER_SKID_EN: adds a one-word holding register so back-to-back frames have no gap
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int DATA_W = SER_DATA_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CLKS_PER_BIT = SER_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              shift_enable,
  output logic              byte_done,
  output logic              busy
);
  localparam int BW = $clog2(DATA_W);
  localparam int PW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  ser_state_t state, state_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic [BW-1:0] bit_cnt, bit_d;
  logic [PW-1:0] cnt_d;
  logic wrap, last, hs, load, se_d;
  assign hs = in_valid && in_ready;
  assign load = state == IDLE && hs;
  assign last = wrap && bit_cnt == BW'(DATA_W - 1);
  byte_serializer_pacer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_pacer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(load),
    .en(state == SHIFT),
    .wrap(wrap),
    .cnt_nxt(cnt_d)
  );
`ifdef BYTE_SERIALIZER_SKID_EN
  logic [DATA_W-1:0] hold, hold_d;
  logic hold_valid, hold_valid_d;
  assign in_ready = !hold_valid;
`else
  assign in_ready = state == IDLE;
`endif
  always_comb begin
    state_d = state;
    sh_d = sh;
    bit_d = bit_cnt;
    if (load) begin
      state_d = SHIFT;
      sh_d = in_data;
      bit_d = '0;
    end else if (wrap) begin
      sh_d = MSB_FIRST ? {sh[DATA_W-2:0], 1'b0} : {1'b0, sh[DATA_W-1:1]};
      bit_d = last ? '0 : bit_cnt + BW'(1);
      state_d = last ? IDLE : SHIFT;
    end
`ifdef BYTE_SERIALIZER_SKID_EN
    hold_d = hold;
    hold_valid_d = hold_valid;
    // a buffered word takes priority at the final wrap; in_ready is low then, so no new word competes
    if (last && hold_valid) begin
      state_d = SHIFT;
      sh_d = hold;
      hold_valid_d = 1'b0;
    end else if (last && hs) begin
      state_d = SHIFT;
      sh_d = in_data;
    end else if (hs && state == SHIFT) begin
      hold_d = in_data;
      hold_valid_d = 1'b1;
    end
`endif
  end
  // outputs are registered from next-state values so they line up with the bit they describe
  assign se_d = state_d == SHIFT && cnt_d == PW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      bit_cnt <= '0;
      serial_out <= 1'b0;
      shift_enable <= 1'b0;
      byte_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      sh <= sh_d;
      bit_cnt <= bit_d;
      serial_out <= state_d == SHIFT && (MSB_FIRST ? sh_d[DATA_W-1] : sh_d[0]);
      shift_enable <= se_d;
      byte_done <= se_d && bit_d == BW'(DATA_W - 1);
      busy <= state_d == SHIFT;
    end
`ifdef BYTE_SERIALIZER_SKID_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold <= '0;
      hold_valid <= 1'b0;
    end else begin
      hold <= hold_d;
      hold_valid <= hold_valid_d;
    end
`endif
endmodule
